// File: rtl/pipe_adder_pkg.sv
// Shared configuration and helpers for the pipelined ripple-carry adder.
// The full adder lives here so every chunk uses the same cell.
package pipe_adder_pkg;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_STAGE_W = 4;

    // Number of pipeline stages; clamped to 1 so a bad configuration still elaborates far enough to report.
    function automatic int calc_stages(input int width, input int stage_w);
        if (stage_w < 1 || width < stage_w) begin
            return 1;
        end
        return width / stage_w;
    endfunction

    function automatic bit cfg_ok(input int width, input int stage_w);
        return (stage_w >= 1) && (width >= stage_w) && ((width % stage_w) == 0);
    endfunction

    // Returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational STAGE_W-bit ripple-carry adder built from full adders.
// Also exposes the carry into its MSB so the top chunk can derive signed overflow.
module rca_chunk
    import pipe_adder_pkg::*;
#(
    parameter int W = DEFAULT_STAGE_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < W; gi++) begin : gen_fa
        assign {carry[gi+1], s[gi]} = full_add(a[gi], b[gi], carry[gi]);
    end

    assign cout     = carry[W];
    assign c_msb_in = carry[W-1];

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one STAGE_W-bit chunk per stage,
// carries registered between stages, valid/ready with a single global advance.
module pipe_rca_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int STAGE_W = DEFAULT_STAGE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, STAGE_W);

    if (!cfg_ok(WIDTH, STAGE_W)) begin : g_cfg_err
        $fatal(1, "pipe_rca_adder: WIDTH must be a positive multiple of STAGE_W");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             ovf_q;
    logic             ovf_d;

    // Subtraction is a + ~b + 1; cin is deliberately ignored in that mode.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;

    // Every stage moves together: a stalled output freezes the whole pipe.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Skew registers: stage gi still carries the operand chunks gi+1..STAGES-1.
    for (genvar gi = 0; gi < STAGES - 1; gi++) begin : gen_skew
        localparam int SW = WIDTH - (gi + 1) * STAGE_W;

        logic [SW-1:0] a_q;
        logic [SW-1:0] b_q;
        logic [SW-1:0] a_d;
        logic [SW-1:0] b_d;

        if (gi == 0) begin : g_src
            assign a_d = a[WIDTH-1:STAGE_W];
            assign b_d = b_eff[WIDTH-1:STAGE_W];
        end else begin : g_src
            assign a_d = gen_skew[gi-1].a_q[SW+STAGE_W-1:STAGE_W];
            assign b_d = gen_skew[gi-1].b_q[SW+STAGE_W-1:STAGE_W];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= '0;
                b_q <= '0;
            end else if (adv) begin
                a_q <= a_d;
                b_q <= b_d;
            end
        end
    end

    // Stage gi adds chunk gi and accumulates the low (gi+1)*STAGE_W result bits.
    for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
        logic [STAGE_W-1:0]         ch_a;
        logic [STAGE_W-1:0]         ch_b;
        logic [STAGE_W-1:0]         ch_s;
        logic                       ch_ci;
        logic                       ch_co;
        logic                       valid_q;
        logic                       valid_d;
        logic                       carry_q;
        logic [(gi+1)*STAGE_W-1:0]  sum_q;
        logic [(gi+1)*STAGE_W-1:0]  sum_d;

        if (gi == 0) begin : g_in
            assign ch_a    = a[STAGE_W-1:0];
            assign ch_b    = b_eff[STAGE_W-1:0];
            assign ch_ci   = cin_eff;
            assign valid_d = in_valid;
            assign sum_d   = ch_s;
        end else begin : g_in
            assign ch_a    = gen_skew[gi-1].a_q[STAGE_W-1:0];
            assign ch_b    = gen_skew[gi-1].b_q[STAGE_W-1:0];
            assign ch_ci   = gen_stage[gi-1].carry_q;
            assign valid_d = gen_stage[gi-1].valid_q;
            assign sum_d   = {ch_s, gen_stage[gi-1].sum_q};
        end

        if (gi == STAGES - 1) begin : g_chunk
            logic ch_cmsb;

            rca_chunk #(
                .W(STAGE_W)
            ) u_chunk (
                .a        (ch_a),
                .b        (ch_b),
                .cin      (ch_ci),
                .s        (ch_s),
                .cout     (ch_co),
                .c_msb_in (ch_cmsb)
            );

            assign ovf_d = ch_cmsb ^ ch_co;
        end else begin : g_chunk
            logic cmsb_unused;

            rca_chunk #(
                .W(STAGE_W)
            ) u_chunk (
                .a        (ch_a),
                .b        (ch_b),
                .cin      (ch_ci),
                .s        (ch_s),
                .cout     (ch_co),
                .c_msb_in (cmsb_unused)
            );
        end

        // Bubbles advance with their slot; only the valid bit marks them.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= valid_d;
                carry_q <= ch_co;
                sum_q   <= sum_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = gen_stage[STAGES-1].valid_q;
    assign sum       = gen_stage[STAGES-1].sum_q;
    assign cout      = gen_stage[STAGES-1].carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Directed self-checking bench for the 16-bit, 4-stage pipelined adder.
module tb_pipe_rca_adder;

    localparam int WIDTH   = 16;
    localparam int STAGE_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    pipe_rca_adder #(
        .WIDTH   (WIDTH),
        .STAGE_W (STAGE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: {ovf, cout, sum}; ovf from the two's-complement sign rule.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        logic [15:0] bb;
        logic [16:0] r;
        logic        v;
        bb = msub ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, bb} + {16'h0000, (msub ? 1'b1 : mcin)};
        v  = (ma[15] == bb[15]) && (r[15] != ma[15]);
        return {v, r[16], r[15:0]};
    endfunction

    // Sends one operation, waits (bounded) for its result and reports latency in clock edges.
    task automatic do_op(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_cin,
                         input logic op_sub, output logic [15:0] r_sum, output logic r_cout,
                         output logic r_ovf, output int lat);
        @(negedge clk);
        a = op_a; b = op_b; cin = op_cin; sub = op_sub; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r_sum = sum; r_cout = cout; r_ovf = ovf;
        $display("[TB] op a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
                 op_a, op_b, op_cin, op_sub, r_sum, r_cout, r_ovf, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++; if (sum !== 16'h0000) begin tests_failed++; $display("FAIL reset_sum: got %h expected 0000", sum); end
        tests_run++; if (cout !== 1'b0) begin tests_failed++; $display("FAIL reset_cout: got %b expected 0", cout); end
        tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned_wrap();
        logic [15:0] s; logic c, v; int lat;
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, v, lat);
        tests_run++; if (lat != 4) begin tests_failed++; $display("FAIL wrap_latency: got %0d expected 4", lat); end
        tests_run++; if (s !== 16'h0000) begin tests_failed++; $display("FAIL wrap_sum: got %h expected 0000", s); end
        tests_run++; if (c !== 1'b1) begin tests_failed++; $display("FAIL wrap_cout: got %b expected 1", c); end
        tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL wrap_ovf: got %b expected 0", v); end
    endtask

    task automatic test_signed_ovf();
        logic [15:0] s; logic c, v; int lat;
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, v, lat);
        tests_run++; if (lat != 4) begin tests_failed++; $display("FAIL ovf_latency: got %0d expected 4", lat); end
        tests_run++; if (s !== 16'h8000) begin tests_failed++; $display("FAIL ovf_sum: got %h expected 8000", s); end
        tests_run++; if (c !== 1'b0) begin tests_failed++; $display("FAIL ovf_cout: got %b expected 0", c); end
        tests_run++; if (v !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b expected 1", v); end
    endtask

    task automatic test_subtract();
        logic [15:0] s; logic c, v; int lat;
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, s, c, v, lat);
        tests_run++; if (lat != 4) begin tests_failed++; $display("FAIL sub_borrow_latency: got %0d expected 4", lat); end
        tests_run++; if (s !== 16'hFFFE) begin tests_failed++; $display("FAIL sub_borrow_sum: got %h expected fffe", s); end
        tests_run++; if (c !== 1'b0) begin tests_failed++; $display("FAIL sub_borrow_cout: got %b expected 0", c); end
        tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL sub_borrow_ovf: got %b expected 0", v); end
        do_op(16'h0007, 16'h0005, 1'b1, 1'b1, s, c, v, lat);
        tests_run++; if (s !== 16'h0002) begin tests_failed++; $display("FAIL sub_pos_sum: got %h expected 0002", s); end
        tests_run++; if (c !== 1'b1) begin tests_failed++; $display("FAIL sub_pos_cout: got %b expected 1", c); end
        tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL sub_pos_ovf: got %b expected 0", v); end
    endtask

    task automatic test_streaming();
        logic [17:0] exp_res [8];
        int got;
        for (int i = 0; i < 8; i++) begin
            exp_res[i] = model(16'(i), 16'(32'h1111 * i), 1'b0, 1'b0);
        end
        got = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    a = 16'(i); b = 16'(32'h1111 * i); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                @(negedge clk);
                for (int cyc = 1; cyc <= 20 && got < 8; cyc++) begin
                    @(negedge clk);
                    if (out_valid === 1'b1) begin
                        $display("[TB] stream result %0d at cycle %0d sum=%h cout=%b ovf=%b", got, cyc, sum, cout, ovf);
                        tests_run++; if (cyc != got + 4) begin tests_failed++; $display("FAIL stream_cycle[%0d]: got %0d expected %0d", got, cyc, got + 4); end
                        tests_run++; if (sum !== exp_res[got][15:0]) begin tests_failed++; $display("FAIL stream_sum[%0d]: got %h expected %h", got, sum, exp_res[got][15:0]); end
                        tests_run++; if ({ovf, cout} !== exp_res[got][17:16]) begin tests_failed++; $display("FAIL stream_flags[%0d]: got %b expected %b", got, {ovf, cout}, exp_res[got][17:16]); end
                        got++;
                    end
                end
            end
        join
        tests_run++; if (got != 8) begin tests_failed++; $display("FAIL stream_count: got %0d expected 8", got); end
    endtask

    task automatic test_backpressure();
        logic [15:0] op_a [6];
        logic [15:0] op_b [6];
        logic        op_s [6];
        logic [17:0] exp_res [6];
        int idx, got, stall_left;
        logic will_accept;
        for (int j = 0; j < 6; j++) begin
            op_a[j] = 16'(32'h1357 * (j + 1));
            op_b[j] = 16'(32'h0F0F ^ (j * 32'h0421));
            op_s[j] = (j == 3);
            exp_res[j] = model(op_a[j], op_b[j], 1'b0, op_s[j]);
        end
        idx = 0; got = 0; stall_left = -1; will_accept = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(negedge clk);
            if (will_accept) idx++;
            in_valid = (idx < 6);
            if (idx < 6) begin a = op_a[idx]; b = op_b[idx]; sub = op_s[idx]; cin = 1'b0; end
            if (stall_left < 0 && out_valid === 1'b1) stall_left = 5;
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
                tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
                tests_run++; if (sum !== exp_res[0][15:0]) begin tests_failed++; $display("FAIL bp_hold_sum: got %h expected %h", sum, exp_res[0][15:0]); end
                tests_run++; if ({ovf, cout} !== exp_res[0][17:16]) begin tests_failed++; $display("FAIL bp_hold_flags: got %b expected %b", {ovf, cout}, exp_res[0][17:16]); end
                stall_left--;
            end
            will_accept = in_valid && in_ready;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                $display("[TB] bp result %0d sum=%h cout=%b ovf=%b", got, sum, cout, ovf);
                tests_run++; if (sum !== exp_res[got][15:0]) begin tests_failed++; $display("FAIL bp_sum[%0d]: got %h expected %h", got, sum, exp_res[got][15:0]); end
                tests_run++; if ({ovf, cout} !== exp_res[got][17:16]) begin tests_failed++; $display("FAIL bp_flags[%0d]: got %b expected %b", got, {ovf, cout}, exp_res[got][17:16]); end
                got++;
            end
        end
        tests_run++; if (got != 6) begin tests_failed++; $display("FAIL bp_count: got %0d expected 6", got); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_no_dup: got out_valid=%b expected 0", out_valid); end
        end
    endtask

    task automatic test_reset_midflight();
        logic [15:0] s; logic c, v; int lat, stale;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            a = 16'(32'h0101 * (j + 1)); b = 16'h0202; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        tests_run++; if (sum !== 16'h0000) begin tests_failed++; $display("FAIL mid_rst_sum: got %h expected 0000", sum); end
        tests_run++; if (cout !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_cout: got %b expected 0", cout); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        tests_run++; if (stale != 0) begin tests_failed++; $display("FAIL mid_stale: got %0d stale cycles expected 0", stale); end
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, s, c, v, lat);
        tests_run++; if (lat != 4) begin tests_failed++; $display("FAIL mid_new_latency: got %0d expected 4", lat); end
        tests_run++; if (s !== 16'h5555) begin tests_failed++; $display("FAIL mid_new_sum: got %h expected 5555", s); end
        tests_run++; if (c !== 1'b0) begin tests_failed++; $display("FAIL mid_new_cout: got %b expected 0", c); end
        tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL mid_new_ovf: got %b expected 0", v); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned_wrap();
        test_signed_ovf();
        test_subtract();
        test_streaming();
        test_backpressure();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_rca_adder.md
Name: pipe_rca_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor.
- The WIDTH-bit operation is split into STAGES = WIDTH/STAGE_W chunks. Each chunk is a STAGE_W-bit ripple adder built from full adders, with its carry registered into the next stage.
- Valid/ready handshakes on input and output, with full backpressure.
- Sits between operand sources and result consumers in datapaths where a single WIDTH-bit ripple chain would miss timing.

Parameters:
- WIDTH, 16: operand/result width in bits; must be a multiple of STAGE_W.
- STAGE_W, 4: bits added per pipeline stage (ripple chain length).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1).
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync release) clears:
  - all stage valid bits, data and carry registers;
  - outputs: out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready is 1 out of reset.
- Global advance enable: adv = !out_valid | out_ready. in_ready = adv (combinational).
- Input transfer: in_valid & in_ready on a rising edge.
  - Stage 0 captures chunk 0 result and carry.
  - Upper operand chunks are captured into skew registers.
  - Effective carry-in: cin when sub=0, 1 when sub=1. B is inverted when sub=1.
- Stage k (1..STAGES-1), on adv:
  - adds chunk k of the skewed operands plus registered carry k-1;
  - forwards lower result chunks, remaining skew operands and valid.
- Final stage:
  - assembles sum;
  - cout = carry out of the top chunk;
  - ovf = carry into bit WIDTH-1 XOR cout, computed inside the top chunk.
- Latency: STAGES cycles from input transfer to out_valid=1 with no stall. STAGES=1 gives latency 1.
- Throughput: one operation per cycle while out_ready=1.
- Bubbles:
  - in_valid=0 with adv=1 inserts an invalid slot.
  - Bubbles advance like data; they are not collapsed.
- Backpressure:
  - out_valid=1 & out_ready=0 freezes every stage (adv=0).
  - sum/cout/ovf are held stable; in_ready=0; no input is accepted.
- Simultaneous output handshake and input transfer in the same cycle: both occur and the pipe shifts by one.
- Output handshake: out_valid & out_ready. The next stage's content (valid or bubble) loads the output register the same edge.
- Reset mid-operation: all in-flight operations are discarded. No result is produced for them after reset release.
- Width rules:
  - all arithmetic is modulo 2^WIDTH;
  - no sign extension; operands are treated as raw bit vectors;
  - sub ignores cin.
- Elaboration: WIDTH % STAGE_W != 0 or STAGE_W < 1 is a fatal elaboration error.

Decomposition:
- Package pipe_adder_pkg:
  - default WIDTH/STAGE_W constants;
  - helper function computing STAGES;
  - localparam checks.
- Sub-module rca_chunk:
  - combinational STAGE_W-bit ripple adder of full adders;
  - inputs a, b, cin; outputs s, cout, and c_msb_in (carry into its MSB) for ovf;
  - instantiated STAGES times via generate.
- Top module holds only registers, skew chain and handshake logic.

Test Plan:
- Unsigned wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles out_valid=1, sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Then a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
- Streaming: 8 back-to-back ops a=i, b=0x1111*i with out_ready=1 -> 8 results in order on consecutive cycles starting at cycle 4, each matching the model.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, output stable. Release -> no loss, no duplication, order preserved.
- Reset mid-flight: assert rst_n=0 with 3 ops in flight -> out_valid=0, sum=0 immediately. After release, no stale results; a new op 0x1234+0x4321 -> 0x5555 after 4 cycles.
